uart_rx: RTL

UART receiver that pairs with the existing transmit-side baud clock generator. It recovers 8N1 frames from an asynchronous serial line using a 16x oversampled baud tick derived from the system clock. Same baud selection as the transmit side. Delivers each received byte with a one-cycle valid pulse and flags framing errors. Sits between the rx pad and the UART register/FIFO layer.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/uart_rx_tick_gen.sv | 26 ++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud divider table for the UART receive path.
package uart_pkg;

    localparam int unsigned CLK_FREQ  = 50_000_000;
    localparam int unsigned OSR       = 16;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BAUD_W    = 17;
    localparam int unsigned TICK_W    = 16;

    localparam logic [BAUD_W-1:0] BAUD_4800  = 17'd4800;
    localparam logic [BAUD_W-1:0] BAUD_9600  = 17'd9600;
    localparam logic [BAUD_W-1:0] BAUD_14400 = 17'd14400;
    localparam logic [BAUD_W-1:0] BAUD_19200 = 17'd19200;
    localparam logic [BAUD_W-1:0] BAUD_38400 = 17'd38400;
    localparam logic [BAUD_W-1:0] BAUD_57600 = 17'd57600;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    // Rounded clk_freq / (rate * osr); every call site passes constants, so this folds away.
    function automatic logic [TICK_W-1:0] div_round(input int unsigned clk_freq,
                                                    input int unsigned rate,
                                                    input int unsigned osr);
        int unsigned d;
        d = rate * osr;
        return TICK_W'((clk_freq + d / 2) / d);
    endfunction

    // Baud select to tick divider; unsupported rates fall back to 9600.
    function automatic logic [TICK_W-1:0] baud_to_tick_max(input logic [BAUD_W-1:0] baud,
                                                           input int unsigned clk_freq = CLK_FREQ,
                                                           input int unsigned osr = OSR);
        logic [TICK_W-1:0] tm;
        case (baud)
            BAUD_4800:  tm = div_round(clk_freq, 32'(BAUD_4800), osr);
            BAUD_14400: tm = div_round(clk_freq, 32'(BAUD_14400), osr);
            BAUD_19200: tm = div_round(clk_freq, 32'(BAUD_19200), osr);
            BAUD_38400: tm = div_round(clk_freq, 32'(BAUD_38400), osr);
            BAUD_57600: tm = div_round(clk_freq, 32'(BAUD_57600), osr);
            default:    tm = div_round(clk_freq, 32'(BAUD_9600), osr);
        endcase
        return tm;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick divider: one-cycle tick every tick_max clocks, held at zero while clear is high.
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [TICK_W-1:0] tick_max,
    output logic              tick
);

    logic [TICK_W-1:0] cnt;

    assign tick = !clear && (cnt == tick_max - TICK_W'(1));

    // Divider counter: restart on clear, wrap after the tick.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, glitch rejection and framing-error reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = uart_pkg::CLK_FREQ,
    parameter int unsigned OSR       = uart_pkg::OSR,
    parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BAUD_W-1:0]    baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned SAMP_W = $clog2(OSR);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [TICK_W-1:0]    tick_max;
    logic                 tick;
    logic                 tick_clear;
    logic [SAMP_W-1:0]    sample_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 mid_start;
    logic                 bit_end;
    logic                 samp_clr;
    logic                 shift_en;
    logic                 done_set;
    logic                 err_set;

    uart_rx_tick_gen u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (tick_clear),
        .tick_max (tick_max),
        .tick     (tick)
    );

    assign mid_start = tick && (sample_cnt == SAMP_W'(OSR / 2 - 1));
    assign bit_end   = tick && (sample_cnt == SAMP_W'(OSR - 1));

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode.
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_next = state;
        tick_clear = 1'b0;
        samp_clr   = 1'b0;
        shift_en   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                tick_clear = 1'b1;
                samp_clr   = 1'b1;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (mid_start) begin
                    samp_clr   = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (rx_s) begin
                        done_set   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, shift register, baud latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_max   <= baud_to_tick_max(BAUD_9600, CLK_FREQ, OSR);
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done   <= done_set;
            frame_err <= err_set;
            busy      <= (state_next != IDLE);

            if (state == IDLE) begin
                tick_max <= baud_to_tick_max(baud, CLK_FREQ, OSR);
                bit_cnt  <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (samp_clr || bit_end) begin
                sample_cnt <= '0;
            end else if (tick) begin
                sample_cnt <= sample_cnt + SAMP_W'(1);
            end

            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end

            if (done_set) begin
                rx_data <= shift_reg;
            end
        end
    end

endmodule
